demux1ne2_buf: RTL

- Buffered 1-to-2 demultiplexer: the reverse-direction companion of the 2-to-1 mux.
- Takes one valid/ready input word and steers it by Sel into one of two independent output FIFOs, each with its own valid/ready drain.
- Used in the datapath to fan a single producer (e.g. writeback/load result) out to two consumers running at different rates.

---
 rtl/demux1ne2_buf.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/demux1ne2_buf.sv
// demux1ne2_buf: buffered 1-to-2 demultiplexer.
// One valid/ready input word is steered by Sel into one of two independent
// output FIFOs, each drained by its own valid/ready consumer.
// Optional feature macro: DEMUX1NE2_STATS_EN adds per-output pop counters
// (Count0/Count1) and a synchronous clear input (Stats_Clr).

// Single output FIFO with a registered head word, valid and full flag.
module demux1ne2_buf_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic             pop_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, rd_nxt;
  logic [PW-1:0]    wr_ptr, wr_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] rdata_nxt;
  logic             push_ok;

  // A full FIFO never accepts a word, even if it is popped in the same cycle.
  assign push_ok = push & ~full;
  assign pop_c   = valid & ready;

  // Next pointers, occupancy and head word; head holds its value when empty.
  always_comb begin
    rd_nxt    = rd_ptr;
    wr_nxt    = wr_ptr;
    count_nxt = count;
    rdata_nxt = rdata;
    if (push_ok) begin
      wr_nxt = wr_ptr + PW'(1);
    end
    if (pop_c) begin
      rd_nxt = rd_ptr + PW'(1);
    end
    if (push_ok && !pop_c) begin
      count_nxt = count + CW'(1);
    end else if (pop_c && !push_ok) begin
      count_nxt = count - CW'(1);
    end
    if (count_nxt != CW'(0)) begin
      // The new head is the slot being written now when the FIFO drains to it.
      if (push_ok && (rd_nxt == wr_ptr)) begin
        rdata_nxt = wdata;
      end else begin
        rdata_nxt = mem[rd_nxt];
      end
    end
  end

  // Pointer, count and registered output state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_nxt;
      count  <= count_nxt;
      rdata  <= rdata_nxt;
      valid  <= (count_nxt != CW'(0));
      full   <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

module demux1ne2_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] In_Data,
  input  logic             In_Valid,
  input  logic             Sel,
  output logic             In_Ready,
  output logic [WIDTH-1:0] Out0_Data,
  output logic             Out0_Valid,
  input  logic             Out0_Ready,
  output logic [WIDTH-1:0] Out1_Data,
  output logic             Out1_Valid,
  input  logic             Out1_Ready,
  output logic             Full0,
  output logic             Full1
`ifdef DEMUX1NE2_STATS_EN
  ,
  input  logic             Stats_Clr,
  output logic [15:0]      Count0,
  output logic [15:0]      Count1
`endif
);

  logic push0, push1;
  logic pop0, pop1;

  // Input is ready whenever the selected destination has room.
  assign In_Ready = Sel ? ~Full1 : ~Full0;
  assign push0    = In_Valid & ~Sel & ~Full0;
  assign push1    = In_Valid &  Sel & ~Full1;

  demux1ne2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (Clock),
    .rst_n (Reset_n),
    .push  (push0),
    .wdata (In_Data),
    .ready (Out0_Ready),
    .rdata (Out0_Data),
    .valid (Out0_Valid),
    .full  (Full0),
    .pop_c (pop0)
  );

  demux1ne2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (Clock),
    .rst_n (Reset_n),
    .push  (push1),
    .wdata (In_Data),
    .ready (Out1_Ready),
    .rdata (Out1_Data),
    .valid (Out1_Valid),
    .full  (Full1),
    .pop_c (pop1)
  );

`ifdef DEMUX1NE2_STATS_EN
  // Saturating pop counters; a clear takes priority over an increment.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Count0 <= '0;
      Count1 <= '0;
    end else if (Stats_Clr) begin
      Count0 <= '0;
      Count1 <= '0;
    end else begin
      if (pop0 && (Count0 != 16'hFFFF)) begin
        Count0 <= Count0 + 16'd1;
      end
      if (pop1 && (Count1 != 16'hFFFF)) begin
        Count1 <= Count1 + 16'd1;
      end
    end
  end
`else
  logic unused_pops;
  assign unused_pops = pop0 ^ pop1;
`endif

endmodule
